// File: rtl/stage5_control_unit_if.sv
// Control bundle between the stage-5 control FSM (master) and its datapath (slave).
interface stage5_control_unit_if;
  logic [15:0] IR;
  logic        ValAZero;
  logic        PCWrite, PCSource, PCAdd;
  logic        MSPWrite, MSPop, RSPWrite, RSPop;
  logic        ValAWrite, ValBWrite, IRWrite;
  logic        MemRead1, MemRead2, MemWrite1, MemWrite2;
  logic [1:0]  MemDst1, MemDst2;
  logic [2:0]  MemData;
  logic [1:0]  ALUOp;
  logic        ResWrite;
  logic        PCRegReset, MSPRegReset, RSPRegReset;
  logic        Halted, IllegalOp;
  logic [15:0] InstrCount;
  logic [3:0]  State;

  modport master (
    input  IR, ValAZero,
    output PCWrite, PCSource, PCAdd, MSPWrite, MSPop, RSPWrite, RSPop,
           ValAWrite, ValBWrite, IRWrite, MemRead1, MemRead2, MemWrite1, MemWrite2,
           MemDst1, MemDst2, MemData, ALUOp, ResWrite,
           PCRegReset, MSPRegReset, RSPRegReset, Halted, IllegalOp, InstrCount, State
  );

  modport slave (
    output IR, ValAZero,
    input  PCWrite, PCSource, PCAdd, MSPWrite, MSPop, RSPWrite, RSPop,
           ValAWrite, ValBWrite, IRWrite, MemRead1, MemRead2, MemWrite1, MemWrite2,
           MemDst1, MemDst2, MemData, ALUOp, ResWrite,
           PCRegReset, MSPRegReset, RSPRegReset, Halted, IllegalOp, InstrCount, State
  );
endinterface

// File: rtl/stage5_control_unit.sv
// Multi-cycle stack-machine control FSM: decodes IR[15:12] and sequences every
// datapath strobe, one instruction at a time.
module stage5_control_unit #(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RegReset,
  stage5_control_unit_if.master bus
);
  typedef enum logic [3:0] {
    S_RESET  = 4'h0, S_FETCH  = 4'h1, S_DECODE = 4'h2, S_PUSH   = 4'h3,
    S_PUSHW  = 4'h4, S_ALU_A  = 4'h5, S_ALU_B  = 4'h6, S_ALU_EX = 4'h7,
    S_ALU_WB = 4'h8, S_BR_A   = 4'h9, S_BR_T   = 4'hA, S_CALL_P = 4'hB,
    S_CALL_W = 4'hC, S_RET_R  = 4'hD, S_RET_J  = 4'hE, S_HALT   = 4'hF
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] icount;
  logic [3:0]  opc;
  logic [3:0]  alu_sel;
  logic        unused_ir;

  assign opc       = bus.IR[15:12];
  assign alu_sel   = opc - 4'd3;
  assign unused_ir = ^bus.IR[11:0];

  always_ff @(posedge CLK) begin
    if (RegReset) begin
      state  <= S_RESET;
      icount <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH) icount <= icount + 16'd1;
    end
  end

  assign bus.State      = state;
  assign bus.InstrCount = icount;

  always_comb begin
    state_nxt       = state;
    bus.PCWrite     = 1'b0; bus.PCSource  = 1'b0; bus.PCAdd     = 1'b0;
    bus.MSPWrite    = 1'b0; bus.MSPop     = 1'b0;
    bus.RSPWrite    = 1'b0; bus.RSPop     = 1'b0;
    bus.ValAWrite   = 1'b0; bus.ValBWrite = 1'b0; bus.IRWrite   = 1'b0;
    bus.MemRead1    = 1'b0; bus.MemRead2  = 1'b0;
    bus.MemWrite1   = 1'b0; bus.MemWrite2 = 1'b0;
    bus.MemDst1     = 2'd0; bus.MemDst2   = 2'd0; bus.MemData   = 3'd0;
    bus.ALUOp       = 2'd0; bus.ResWrite  = 1'b0;
    bus.PCRegReset  = 1'b0; bus.MSPRegReset = 1'b0; bus.RSPRegReset = 1'b0;
    bus.Halted      = 1'b0; bus.IllegalOp = 1'b0;

    unique case (state)
      S_RESET: begin
        bus.PCRegReset = 1'b1; bus.MSPRegReset = 1'b1; bus.RSPRegReset = 1'b1;
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        bus.MemRead1 = 1'b1; bus.IRWrite = 1'b1; bus.PCWrite = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        unique case (opc)
          4'h0: state_nxt = S_FETCH;
          4'h1: state_nxt = S_PUSH;
          4'h2: begin
            bus.MSPWrite = 1'b1; bus.MSPop = 1'b1;
            state_nxt = S_FETCH;
          end
          4'h3, 4'h4, 4'h5, 4'h6: state_nxt = S_ALU_A;
          // Relative jump: adder sees PC already advanced by FETCH.
          4'h8: begin
            bus.PCWrite = 1'b1; bus.PCAdd = 1'b1;
            state_nxt = S_FETCH;
          end
          4'h9: state_nxt = S_BR_A;
          4'hA: state_nxt = S_CALL_P;
          4'hB: state_nxt = S_RET_R;
          4'hF: state_nxt = S_HALT;
          default: begin
            bus.IllegalOp = 1'b1;
            state_nxt = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_PUSH: begin
        bus.MSPWrite = 1'b1;
        state_nxt = S_PUSHW;
      end
      S_PUSHW: begin
        bus.MemWrite2 = 1'b1; bus.MemData = 3'd2;
        state_nxt = S_FETCH;
      end
      S_ALU_A: begin
        bus.MemRead2 = 1'b1; bus.ValAWrite = 1'b1;
        bus.MSPWrite = 1'b1; bus.MSPop = 1'b1;
        state_nxt = S_ALU_B;
      end
      S_ALU_B: begin
        bus.MemRead1 = 1'b1; bus.MemDst1 = 2'd1; bus.ValBWrite = 1'b1;
        state_nxt = S_ALU_EX;
      end
      S_ALU_EX: begin
        bus.ResWrite = 1'b1; bus.ALUOp = alu_sel[1:0];
        state_nxt = S_ALU_WB;
      end
      S_ALU_WB: begin
        bus.MemWrite2 = 1'b1; bus.MemData = 3'd1;
        state_nxt = S_FETCH;
      end
      S_BR_A: begin
        bus.MemRead2 = 1'b1; bus.ValAWrite = 1'b1;
        bus.MSPWrite = 1'b1; bus.MSPop = 1'b1;
        state_nxt = S_BR_T;
      end
      S_BR_T: begin
        bus.PCWrite = bus.ValAZero; bus.PCAdd = bus.ValAZero;
        state_nxt = S_FETCH;
      end
      S_CALL_P: begin
        bus.RSPWrite = 1'b1;
        state_nxt = S_CALL_W;
      end
      // Memory latches the pre-edge PC as the return address while PC jumps.
      S_CALL_W: begin
        bus.MemWrite2 = 1'b1; bus.MemDst2 = 2'd1; bus.MemData = 3'd0;
        bus.PCWrite = 1'b1; bus.PCAdd = 1'b1;
        state_nxt = S_FETCH;
      end
      S_RET_R: begin
        bus.MemRead2 = 1'b1; bus.MemDst2 = 2'd1; bus.ValAWrite = 1'b1;
        bus.RSPWrite = 1'b1; bus.RSPop = 1'b1;
        state_nxt = S_RET_J;
      end
      S_RET_J: begin
        bus.PCWrite = 1'b1; bus.PCSource = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        bus.Halted = 1'b1;
        state_nxt = S_HALT;
      end
      default: state_nxt = S_RESET;
    endcase
  end
endmodule

// File: tb/tb_stage5_control_unit.sv
// Directed bench for stage5_control_unit: walks reset, PUSHI/ADD, BEQZ, CALL/RET,
// illegal, POP, reset mid-ALU and HALT, checking strobes cycle by cycle.
module tb_stage5_control_unit;
  logic CLK = 1'b0;
  logic RegReset;
  int   tests = 0;
  int   fails = 0;

  stage5_control_unit_if bus ();
  stage5_control_unit #(.HALT_ON_ILLEGAL(1'b0)) dut (
    .CLK(CLK), .RegReset(RegReset), .bus(bus)
  );

  always #5 CLK = ~CLK;

  logic [13:0] strobes;
  assign strobes = {bus.PCWrite, bus.MSPWrite, bus.RSPWrite, bus.ValAWrite,
                    bus.ValBWrite, bus.IRWrite, bus.MemRead1, bus.MemRead2,
                    bus.MemWrite1, bus.MemWrite2, bus.ResWrite,
                    bus.PCRegReset, bus.MSPRegReset, bus.RSPRegReset};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RegReset = 1'b1;
    bus.IR = 16'h0000;
    bus.ValAZero = 1'b0;
    tick(); tick();
    chk("rst_state", bus.State, 0);
    chk("rst_regresets", {bus.PCRegReset, bus.MSPRegReset, bus.RSPRegReset}, 3'b111);
    chk("rst_icount", bus.InstrCount, 0);

    RegReset = 1'b0;
    tick();
    chk("fetch_state", bus.State, 1);
    chk("fetch_strobes", {bus.MemRead1, bus.IRWrite, bus.PCWrite, bus.MemDst1, bus.PCAdd}, 6'b111000);
    chk("fetch_no_regreset", {bus.PCRegReset, bus.MSPRegReset, bus.RSPRegReset}, 3'b000);

    // PUSHI 5
    bus.IR = 16'h1005;
    tick(); chk("pushi_decode", bus.State, 2);
    chk("pushi_icount", bus.InstrCount, 1);
    tick(); chk("push_state", bus.State, 3);
    chk("push_msp", {bus.MSPWrite, bus.MSPop}, 2'b10);
    tick(); chk("pushw_state", bus.State, 4);
    chk("pushw_mem", {bus.MemWrite2, bus.MemDst2, bus.MemData}, {1'b1, 2'd0, 3'd2});
    tick(); chk("pushi_back_fetch", bus.State, 1);

    // ADD
    bus.IR = 16'h3000;
    tick(); chk("add_decode", bus.State, 2);
    tick(); chk("alu_a_state", bus.State, 5);
    chk("alu_a_strb", {bus.MemRead2, bus.ValAWrite, bus.MSPWrite, bus.MSPop, bus.MemDst2}, {4'b1111, 2'd0});
    tick(); chk("alu_b_state", bus.State, 6);
    chk("alu_b_strb", {bus.MemRead1, bus.MemDst1, bus.ValBWrite, bus.MSPWrite}, {1'b1, 2'd1, 1'b1, 1'b0});
    tick(); chk("alu_ex_state", bus.State, 7);
    chk("alu_ex_op", {bus.ResWrite, bus.ALUOp}, 3'b100);
    tick(); chk("alu_wb_state", bus.State, 8);
    chk("alu_wb_mem", {bus.MemWrite2, bus.MemData, bus.ResWrite}, {1'b1, 3'd1, 1'b0});
    chk("add_icount", bus.InstrCount, 2);
    tick(); chk("add_back_fetch", bus.State, 1);

    // BEQZ, both ValAZero polarities in BR_T
    bus.IR = 16'h9003;
    bus.ValAZero = 1'b1;
    tick(); chk("beqz_decode_idle", strobes, 0);
    tick(); chk("br_a_state", bus.State, 9);
    chk("br_a_strb", {bus.MemRead2, bus.ValAWrite, bus.MSPWrite, bus.MSPop}, 4'b1111);
    tick(); chk("br_t_state", bus.State, 10);
    chk("br_t_taken", {bus.PCWrite, bus.PCAdd}, 2'b11);
    bus.ValAZero = 1'b0;
    #1;
    chk("br_t_not_taken", {bus.PCWrite, bus.PCAdd}, 2'b00);
    tick(); chk("beqz_back_fetch", bus.State, 1);

    // CALL
    bus.IR = 16'hA010;
    tick(); tick();
    chk("call_p_state", bus.State, 11);
    chk("call_p_rsp", {bus.RSPWrite, bus.RSPop}, 2'b10);
    tick(); chk("call_w_state", bus.State, 12);
    chk("call_w_strb", {bus.MemWrite2, bus.MemDst2, bus.MemData, bus.PCWrite, bus.PCAdd, bus.PCSource},
        {1'b1, 2'd1, 3'd0, 1'b1, 1'b1, 1'b0});
    tick(); chk("call_back_fetch", bus.State, 1);

    // RET
    bus.IR = 16'hB000;
    tick(); tick();
    chk("ret_r_state", bus.State, 13);
    chk("ret_r_strb", {bus.MemRead2, bus.MemDst2, bus.ValAWrite, bus.RSPWrite, bus.RSPop}, {1'b1, 2'd1, 3'b111});
    tick(); chk("ret_j_state", bus.State, 14);
    chk("ret_j_strb", {bus.PCWrite, bus.PCSource, bus.PCAdd}, 3'b110);
    tick(); chk("ret_back_fetch", bus.State, 1);

    // Illegal opcode: one-cycle pulse then fetch
    bus.IR = 16'h7000;
    tick(); chk("illegal_pulse", {bus.State, bus.IllegalOp}, {4'd2, 1'b1});
    tick(); chk("illegal_next", {bus.State, bus.IllegalOp}, {4'd1, 1'b0});

    // POP
    bus.IR = 16'h2000;
    tick(); chk("pop_strb", {bus.MSPWrite, bus.MSPop, bus.IllegalOp}, 3'b110);
    tick(); chk("pop_back_fetch", bus.State, 1);
    chk("pop_icount", bus.InstrCount, 7);

    // Reset during ALU_B abandons the instruction
    bus.IR = 16'h4000;
    tick(); tick(); tick();
    chk("mid_alu_b", bus.State, 6);
    RegReset = 1'b1;
    tick(); chk("mid_rst_state", bus.State, 0);
    chk("mid_rst_strobes", strobes, 14'b00000000000111);
    chk("mid_rst_icount", bus.InstrCount, 0);
    RegReset = 1'b0;
    tick(); chk("mid_rst_fetch", bus.State, 1);

    // HALT holds with no strobes
    bus.IR = 16'hF000;
    tick(); tick();
    for (int i = 0; i < 20; i++) begin
      chk("halt_hold", {bus.State, bus.Halted, strobes}, {4'hF, 1'b1, 14'd0});
      tick();
    end
    chk("halt_icount", bus.InstrCount, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/stage5_control_unit.md
Name: stage5_control_unit

Overview:
- Multi-cycle control FSM driving the stage-5 datapath: PC/MSP/RSP incrementers, two-port memory stage, and ValA/ValB/IR registers.
- Decodes IR[15:12] and sequences every datapath strobe and mux select, one instruction at a time.
- It is the initiator side of the datapath control interface; the datapath only responds.

Parameters:
HALT_ON_ILLEGAL  0  1: an illegal opcode enters HALT; 0: pulse IllegalOp and continue with the next fetch.

Ports:
CLK  input  1  system clock; all state changes on rising edge
RegReset  input  1  synchronous active-high reset
IR  input  16  instruction register contents (datapath IROut)
ValAZero  input  1  high when datapath ValAOut == 16'h0000
PCWrite, PCSource, PCAdd  output  1 each  PC control
MSPWrite, MSPop, RSPWrite, RSPop  output  1 each  stack pointer control
ValAWrite, ValBWrite, IRWrite  output  1 each  register load enables
MemRead1, MemRead2, MemWrite1, MemWrite2  output  1 each  memory strobes
MemDst1, MemDst2  output  2 each  memory address selects
MemData  output  3  memory write-data select
ALUOp  output  2  00 ADD, 01 SUB, 10 AND, 11 OR
ResWrite  output  1  ALU result register load
PCRegReset, MSPRegReset, RSPRegReset  output  1 each  datapath register resets
Halted  output  1  high while in HALT
IllegalOp  output  1  one-cycle pulse on an illegal opcode
InstrCount  output  16  number of fetches since reset
State  output  4  current state, for debug

Behaviour:
- Encodings:
  - MemDst1: 0 = PC, 1 = MSP. MemDst2: 0 = MSP, 1 = RSP.
  - MemData: 0 = PC, 1 = Res, 2 = ZEImm.
  - PCSource: 0 = adder, 1 = ValA. PCAdd: 0 = +1, 1 = +SignExt.
  - xSPop: 0 = decrement (push), 1 = increment (pop).
  - ValA loads from port-2 read data; ValB and IR load from port-1 read data.
- Default output value: every strobe 0 and every select 0 in any state not listed below.
- Reset:
  - RegReset high at an edge puts the FSM in RESET (0) and clears InstrCount. Applies mid-instruction too: the instruction is abandoned, with no further strobes.
  - RESET drives PC/MSP/RSPRegReset = 1, then moves to FETCH. Those three outputs are 0 in every other state.
- FETCH (1): MemRead1, MemDst1 = PC, IRWrite, PCWrite (PCSource 0, PCAdd 0), InstrCount += 1 (wraps FFFF -> 0000). Next: DECODE.
- DECODE (2): outputs depend on IR[15:12].
  - 0 NOP: go to FETCH.
  - 1 PUSHI: go to PUSH.
  - 2 POP: MSPWrite, MSPop = 1; go to FETCH.
  - 3–6 ADD/SUB/AND/OR: go to ALU_A.
  - 8 JUMP: PCWrite, PCAdd = 1 (target = PC+1+sext); go to FETCH.
  - 9 BEQZ: go to BR_A.
  - A CALL: go to CALL_P.
  - B RET: go to RET_R.
  - F HALT: go to HALT.
  - 7, C, D, E illegal: IllegalOp = 1; go to HALT if HALT_ON_ILLEGAL, else FETCH.
- Push immediate:
  - PUSH (3): MSPWrite, MSPop = 0.
  - PUSHW (4): MemWrite2, MemDst2 = MSP, MemData = ZEImm. Next: FETCH.
- ALU instructions:
  - ALU_A (5): MemRead2, MemDst2 = MSP, ValAWrite, MSPWrite, MSPop = 1.
  - ALU_B (6): MemRead1, MemDst1 = MSP, ValBWrite.
  - ALU_EX (7): ResWrite, ALUOp = opcode − 3.
  - ALU_WB (8): MemWrite2, MemDst2 = MSP, MemData = Res. Next: FETCH.
  - Net effect: the two top stack entries are replaced by their result; MSP rises by 1.
- Branch if zero:
  - BR_A (9): MemRead2, MemDst2 = MSP, ValAWrite, MSPWrite, MSPop = 1.
  - BR_T (A): if ValAZero, PCWrite with PCAdd = 1. Next: FETCH.
- Call:
  - CALL_P (B): RSPWrite, RSPop = 0.
  - CALL_W (C): MemWrite2, MemDst2 = RSP, MemData = PC, plus PCWrite with PCAdd = 1 in the same cycle. Memory captures the pre-edge PC (the return address). Next: FETCH.
- Return:
  - RET_R (D): MemRead2, MemDst2 = RSP, ValAWrite, RSPWrite, RSPop = 1.
  - RET_J (E): PCWrite, PCSource = 1. Next: FETCH.
- HALT (F): Halted = 1, all strobes 0. Only RegReset exits.
- Output timing: outputs are combinational from State, plus IR in DECODE and ValAZero in BR_T. No strobe is ever asserted in two consecutive cycles unless listed above.
- Cycle counts (FETCH through last state): NOP/POP/JUMP 2, PUSHI 4, ALU 6, BEQZ 4, CALL 4, RET 4.
- MemWrite1 is never asserted.

Test Plan:
- Reset: hold RegReset 2 cycles -> State = 0, all three *RegReset = 1, InstrCount = 0. Release -> FETCH with MemRead1 = IRWrite = PCWrite = 1.
- PUSHI then ADD: IR = 1005, then IR = 3000 -> PUSHI asserts MemData = 2 on MemWrite2 in cycle 4. ADD runs 6 cycles with ALUOp = 00 in ALU_EX, MemData = 1 in ALU_WB. InstrCount = 2.
- BEQZ: ValAZero = 1 -> PCWrite = 1, PCAdd = 1 in BR_T. ValAZero = 0 -> PCWrite = 0 in BR_T.
- CALL/RET: IR = A010 -> CALL_W has MemDst2 = 1, MemData = 0, PCWrite = 1, PCAdd = 1. IR = B000 -> RET_J has PCSource = 1.
- Illegal and halt: IR = 7000 with HALT_ON_ILLEGAL = 0 -> IllegalOp pulses 1 cycle, then FETCH. IR = F000 -> Halted stays 1 for 20 cycles with no strobes.
- Reset mid-ALU: assert RegReset during ALU_B -> next State = 0 with no ValBWrite/ResWrite afterwards; InstrCount = 0; FETCH follows.
